// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
// Contents:
//   state_t     - receiver FSM state encoding
//   *_MIN/*_MAX - legal ranges for the receiver parameters
//   params_ok   - reports whether a parameter set is inside those ranges
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 8;
    localparam int OVERSAMPLE_MAX = 32;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;

    function automatic bit params_ok(input int data_bits, input int oversample,
                                     input int stop_bits);
        return (data_bits >= DATA_BITS_MIN) && (data_bits <= DATA_BITS_MAX) &&
               (oversample >= OVERSAMPLE_MIN) && (oversample <= OVERSAMPLE_MAX) &&
               ((oversample % 2) == 0) &&
               (stop_bits >= STOP_BITS_MIN) && (stop_bits <= STOP_BITS_MAX);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-to-consumer bus: received word, valid/ready handshake, error
// pulses and busy status.
// Modports:
//   master - receiver side: drives rx_data, rx_valid, frame_err, parity_err,
//            overrun, busy; samples rx_ready
//   slave  - consumer side: the reverse
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports:
//   clk - system clock
//   rst - synchronous, active-low reset; both flops reset to 1 (line idle)
//   d   - asynchronous input
//   q   - synchronized output
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with oversampled bit timing, optional parity,
// one or two stop bits, break handling and a valid/ready output register.
// Ports:
//   clk     - system clock
//   rst     - synchronous, active-low reset
//   tick_en - one-clk pulse at OVERSAMPLE x baud; all bit timing uses it
//   rxd     - asynchronous serial line, idles high
//   bus     - master side of uart_rx_cfg_if (word, handshake, error pulses, busy)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle, waiting for a low sample on a tick
// ST_START  | confirming the start bit at its midpoint
// ST_DATA   | sampling data bits mid-bit, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling stop bits; last good one completes the frame
// ST_BREAK  | stop bit was low; wait for the line to return high
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick_en,
    input  logic           rxd,
    uart_rx_cfg_if.master  bus
);
    if (!params_ok(DATA_BITS, OVERSAMPLE, STOP_BITS)) begin : g_param_err
        $error("uart_rx_cfg: parameter set outside the supported range");
    end

    localparam int             CW        = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    logic                 rxd_s;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 perr_q;
    logic                 ovr_q;
    logic                 busy_q;
    logic                 par_bad;
    logic                 bit_tick;
    logic                 good_done;
    logic                 xfer;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Mid-bit sample point for DATA/PARITY/STOP.
    assign bit_tick  = tick_en && (cnt == CNT_LAST);
    // Last stop bit sampled high with clean parity: a deliverable word.
    assign good_done = (state == ST_STOP) && bit_tick && rxd_s &&
                       (bit_idx == STOP_LAST) && !par_bad;
    assign xfer      = valid_q && bus.rx_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
            par_bad <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
            ovr_q  <= 1'b0;

            // A completing word may reuse the slot in the same cycle it is read.
            if (good_done) begin
                if (!valid_q || bus.rx_ready) begin
                    data_q  <= shreg;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (xfer) begin
                valid_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (tick_en && !rxd_s) begin
                        state  <= ST_START;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                    end
                end
                ST_START: begin
                    if (tick_en) begin
                        if (cnt == CNT_HALF) begin
                            cnt <= '0;
                            if (!rxd_s) begin
                                state   <= ST_DATA;
                                bit_idx <= '0;
                                par_bad <= 1'b0;
                            end else begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else if (tick_en) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        par_bad <= (((^shreg) ^ rxd_s) != 1'(PARITY_ODD));
                        state   <= ST_STOP;
                    end else if (tick_en) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        // Both error pulses leave in the same cycle.
                        if (!rxd_s) begin
                            ferr_q  <= 1'b1;
                            perr_q  <= par_bad;
                            bit_idx <= '0;
                            state   <= ST_BREAK;
                        end else if (bit_idx == STOP_LAST) begin
                            perr_q  <= par_bad;
                            bit_idx <= '0;
                            state   <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else if (tick_en) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rxd_s) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = perr_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: three receivers (8N1, 8E1, 7N2) on shared
// clock/tick/reset with separate serial lines. Expected words go into a
// queue per receiver; a monitor pops and compares on every transfer and
// counts flag pulses, which the stimulus then compares against.
module tb_uart_rx_cfg;
    localparam int BIT_CLKS = 32;   // 16 ticks per bit, one tick every 2 clks

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick_en = 1'b0;
    logic rxd0 = 1'b1;
    logic rxd1 = 1'b1;
    logic rxd2 = 1'b1;

    int n_checks = 0;
    int n_err    = 0;
    int n_valid[3] = '{0, 0, 0};
    int n_ferr[3]  = '{0, 0, 0};
    int n_perr[3]  = '{0, 0, 0};
    int n_ovr[3]   = '{0, 0, 0};

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    uart_rx_cfg_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) bus1 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) bus2 ();

    uart_rx_cfg u0 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .rxd(rxd0), .bus(bus0.master)
    );
    uart_rx_cfg #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .rxd(rxd1), .bus(bus1.master)
    );
    uart_rx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .rxd(rxd2), .bus(bus2.master)
    );

    always #5 clk = ~clk;
    always @(negedge clk) tick_en = ~tick_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int d, input logic [8:0] got);
        logic [8:0] e;
        int sz;
        case (d)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL sb_unexpected_d%0d: got %0h expected no word", d, got);
        end else begin
            case (d)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("sb_data_d%0d", d), 32'(got), 32'(e));
        end
    endtask

    // Monitor: samples just after the falling edge, away from the active edge.
    always begin
        @(negedge clk);
        #1;
        if (bus0.rx_valid) n_valid[0]++;
        if (bus1.rx_valid) n_valid[1]++;
        if (bus2.rx_valid) n_valid[2]++;
        if (bus0.frame_err) n_ferr[0]++;
        if (bus1.frame_err) n_ferr[1]++;
        if (bus2.frame_err) n_ferr[2]++;
        if (bus0.parity_err) n_perr[0]++;
        if (bus1.parity_err) n_perr[1]++;
        if (bus2.parity_err) n_perr[2]++;
        if (bus0.overrun) n_ovr[0]++;
        if (bus1.overrun) n_ovr[1]++;
        if (bus2.overrun) n_ovr[2]++;
        if (rst && bus0.rx_valid && bus0.rx_ready) sb_pop(0, {1'b0, bus0.rx_data});
        if (rst && bus1.rx_valid && bus1.rx_ready) sb_pop(1, {1'b0, bus1.rx_data});
        if (rst && bus2.rx_valid && bus2.rx_ready) sb_pop(2, {2'b00, bus2.rx_data});
    end

    task automatic set_line(input int d, input logic v);
        case (d)
            0: rxd0 = v;
            1: rxd1 = v;
            default: rxd2 = v;
        endcase
    endtask

    task automatic drive_bit(input int d, input logic v);
        set_line(d, v);
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
    task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                              input int par, input logic stop_v, input int nstop);
        drive_bit(d, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d, data[i]);
        if (par >= 0) drive_bit(d, par[0]);
        for (int i = 0; i < nstop; i++) drive_bit(d, stop_v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "tb_uart_rx_cfg timeout");
    end

    initial begin
        int b;
        bus0.rx_ready = 1'b1;
        bus1.rx_ready = 1'b1;
        bus2.rx_ready = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_u0", {23'd0, bus0.rx_data, bus0.rx_valid, bus0.busy,
                           bus0.frame_err, bus0.parity_err, bus0.overrun}, 32'd0);
        check("reset_u1", {23'd0, bus1.rx_data, bus1.rx_valid, bus1.busy,
                           bus1.frame_err, bus1.parity_err, bus1.overrun}, 32'd0);
        check("reset_u2", {24'd0, bus2.rx_data, bus2.rx_valid, bus2.busy,
                           bus2.frame_err, bus2.parity_err, bus2.overrun}, 32'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);

        // 0xA5 8N1 with ready held high
        b = n_valid[0];
        q0.push_back(9'h0A5);
        send_frame(0, 9'h0A5, 8, -1, 1'b1, 1);
        repeat (40) @(negedge clk);
        check("a5_valid_width", 32'(n_valid[0] - b), 32'd1);
        check("a5_no_flags", 32'(n_ferr[0] + n_perr[0] + n_ovr[0]), 32'd0);

        // False start: 4 ticks low
        b = n_valid[0];
        set_line(0, 1'b0);
        repeat (8) @(negedge clk);
        check("fs_busy_high", 32'(bus0.busy), 32'd1);
        set_line(0, 1'b1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("fs_busy_low", 32'(bus0.busy), 32'd0);
        check("fs_no_valid", 32'(n_valid[0] - b), 32'd0);
        check("fs_no_flags", 32'(n_ferr[0] + n_perr[0] + n_ovr[0]), 32'd0);

        // Even parity, 0x37 has five ones: parity bit 0 is wrong, 1 is right
        send_frame(1, 9'h037, 8, 0, 1'b1, 1);
        repeat (40) @(negedge clk);
        check("par_bad_perr", 32'(n_perr[1]), 32'd1);
        check("par_bad_no_valid", 32'(n_valid[1]), 32'd0);
        check("par_bad_no_ferr", 32'(n_ferr[1]), 32'd0);
        q1.push_back(9'h037);
        send_frame(1, 9'h037, 8, 1, 1'b1, 1);
        repeat (40) @(negedge clk);
        check("par_ok_perr", 32'(n_perr[1]), 32'd1);
        check("par_ok_valid", 32'(n_valid[1]), 32'd1);

        // Low stop bit followed by 3 bit times of low line
        send_frame(0, 9'h0FF, 8, -1, 1'b0, 1);
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("brk_busy", 32'(bus0.busy), 32'd1);
        check("brk_ferr", 32'(n_ferr[0]), 32'd1);
        set_line(0, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        check("brk_exit_busy", 32'(bus0.busy), 32'd0);
        q0.push_back(9'h05A);
        send_frame(0, 9'h05A, 8, -1, 1'b1, 1);
        repeat (40) @(negedge clk);
        check("brk_ferr_once", 32'(n_ferr[0]), 32'd1);
        check("brk_no_perr", 32'(n_perr[0]), 32'd0);

        // Overrun: two back-to-back frames with ready low
        bus0.rx_ready = 1'b0;
        q0.push_back(9'h011);
        send_frame(0, 9'h011, 8, -1, 1'b1, 1);
        send_frame(0, 9'h022, 8, -1, 1'b1, 1);
        repeat (40) @(negedge clk);
        check("ovr_pulse", 32'(n_ovr[0]), 32'd1);
        check("ovr_data_kept", 32'(bus0.rx_data), 32'h11);
        check("ovr_valid_held", 32'(bus0.rx_valid), 32'd1);
        bus0.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ovr_valid_clr", 32'(bus0.rx_valid), 32'd0);

        // 7 data bits, 2 stop bits; reset mid-frame
        bus2.rx_ready = 1'b0;
        send_frame(2, 9'h041, 7, -1, 1'b1, 2);
        repeat (40) @(negedge clk);
        check("d7_hold_valid", 32'(bus2.rx_valid), 32'd1);
        check("d7_hold_data", 32'(bus2.rx_data), 32'h41);
        drive_bit(2, 1'b0);
        drive_bit(2, 1'b1);
        drive_bit(2, 1'b1);
        set_line(2, 1'b1);
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("d7_busy_mid", 32'(bus2.busy), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("d7_reset_out", {24'd0, bus2.rx_data, bus2.rx_valid, bus2.busy,
                               bus2.frame_err, bus2.parity_err, bus2.overrun}, 32'd0);
        rst = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("d7_idle_after_rst", 32'(bus2.busy), 32'd0);
        check("d7_no_ferr", 32'(n_ferr[2]), 32'd0);
        bus2.rx_ready = 1'b1;
        q2.push_back(9'h03C);
        send_frame(2, 9'h03C, 7, -1, 1'b1, 2);
        repeat (40) @(negedge clk);
        check("d7_no_flags", 32'(n_ferr[2] + n_perr[2] + n_ovr[2]), 32'd0);

        check("sb_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
